log_div_seq: RTL and testbench

- Sequential Mitchell-style logarithmic divider. It is the inverse-direction companion to the combinational logarithmic multiplier.
- Converts each operand to a base-2 log (leading-one position plus fraction), subtracts the logs, and applies a piecewise-linear antilog to produce a fixed-point quotient.
- Multi-cycle FSM with valid/ready handshakes on both sides; sits beside the multiplier in the arithmetic datapath.

---
 rtl/log_div_seq_if.sv | 31 +++
 rtl/log_div_seq.sv | 184 ++++++++++++++++++
 tb/tb_log_div_seq.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/log_div_seq_if.sv
// rtl/log_div_seq_if.sv - operand/result handshake bundle for log_div_seq
// Ports (signals):
//   in_valid / in_ready   : operand pair handshake
//   a, b                  : dividend, divisor (unsigned, n bits)
//   out_valid / out_ready : result handshake
//   quotient              : n+FRAC bit unsigned fixed point, FRAC fractional bits
//   dz                    : divide-by-zero flag
// Modports: master drives operands and consumes results; slave is the divider.
interface log_div_seq_if #(
  parameter int n    = 16,
  parameter int FRAC = 8
);
  logic                in_valid;
  logic                in_ready;
  logic [n-1:0]        a;
  logic [n-1:0]        b;
  logic                out_valid;
  logic                out_ready;
  logic [n+FRAC-1:0]   quotient;
  logic                dz;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, quotient, dz
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, quotient, dz
  );
endinterface

// File: rtl/log_div_seq.sv
// rtl/log_div_seq.sv - sequential Mitchell logarithmic divider with valid/ready handshakes
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   div_if : log_div_seq_if.slave (in_valid/in_ready/a/b, out_valid/out_ready/quotient/dz)
// Flow: IDLE -accept-> LOG -> SUB -> ALOG -> DONE -out_ready-> IDLE
module log_div_seq #(
  parameter int n    = 16,
  parameter int FRAC = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  log_div_seq_if.slave  div_if
);

  localparam int KW  = $clog2(n);   // leading-one index width
  localparam int KSW = KW + 2;      // signed exponent difference width
  localparam int XW  = n - 1;       // log fraction width
  localparam int QW  = n + FRAC;    // quotient width

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOG  = 3'd1,
    SUB  = 3'd2,
    ALOG = 3'd3,
    DONE = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [n-1:0]          a_q, a_d;
  logic [n-1:0]          b_q, b_d;
  logic [KW-1:0]         ka_q, ka_d;
  logic [KW-1:0]         kb_q, kb_d;
  logic [XW-1:0]         xa_q, xa_d;
  logic [XW-1:0]         xb_q, xb_d;
  logic                  za_q, za_d;
  logic                  zb_q, zb_d;
  logic signed [KSW-1:0] k_q, k_d;
  logic [n-1:0]          m_q, m_d;
  logic [QW-1:0]         quot_q, quot_d;
  logic                  dz_q, dz_d;

  // Datapath helpers
  logic [KW-1:0]         lead_a, lead_b;
  logic signed [KSW-1:0] ka_ext, kb_ext;
  logic                  sub_borrow;
  int                    alog_shift;
  logic [QW-1:0]         m_wide;
  logic [QW-1:0]         alog_q;

  // Index of the most significant set bit; 0 for a zero operand.
  function automatic logic [KW-1:0] lead_one(input logic [n-1:0] v);
    logic [KW-1:0] r;
    r = '0;
    for (int i = 0; i < n; i++) begin
      if (v[i]) r = KW'(i);
    end
    return r;
  endfunction

  // Bits below the leading one, left-aligned into XW bits. Shifting the
  // leading one up to bit n-1 and keeping the low XW bits drops it.
  function automatic logic [XW-1:0] frac_bits(input logic [n-1:0] v,
                                              input logic [KW-1:0] k);
    logic [KW-1:0] shamt;
    shamt = KW'(n - 1) - k;
    return XW'(v << shamt);
  endfunction

  always_comb begin
    lead_a     = lead_one(a_q);
    lead_b     = lead_one(b_q);
    ka_ext     = signed'({2'b00, ka_q});
    kb_ext     = signed'({2'b00, kb_q});
    sub_borrow = (xa_q < xb_q);
    // Antilog scale: M carries XW fractional bits, quotient carries FRAC.
    alog_shift = int'(k_q) + FRAC - (n - 1);
    m_wide     = {{FRAC{1'b0}}, m_q};
    if (alog_shift >= 0) begin
      alog_q = m_wide << alog_shift;
    end else begin
      alog_q = m_wide >> (-alog_shift);
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    ka_d    = ka_q;
    kb_d    = kb_q;
    xa_d    = xa_q;
    xb_d    = xb_q;
    za_d    = za_q;
    zb_d    = zb_q;
    k_d     = k_q;
    m_d     = m_q;
    quot_d  = quot_q;
    dz_d    = dz_q;

    case (state_q)
      IDLE: begin
        if (div_if.in_valid) begin
          a_d     = div_if.a;
          b_d     = div_if.b;
          state_d = LOG;
        end
      end
      LOG: begin
        ka_d    = lead_a;
        kb_d    = lead_b;
        xa_d    = frac_bits(a_q, lead_a);
        xb_d    = frac_bits(b_q, lead_b);
        za_d    = (a_q == '0);
        zb_d    = (b_q == '0);
        state_d = SUB;
      end
      SUB: begin
        // A fraction borrow moves one unit out of the exponent. The XW-bit
        // wrapping difference already equals 2^XW + xa - xb in that case, so
        // the mantissa is the implicit one on top of the wrapped difference.
        k_d     = ka_ext - kb_ext - {{(KSW-1){1'b0}}, sub_borrow};
        m_d     = {1'b1, xa_q - xb_q};
        state_d = ALOG;
      end
      ALOG: begin
        if (zb_q) begin
          quot_d = '1;
          dz_d   = 1'b1;
        end else if (za_q) begin
          quot_d = '0;
          dz_d   = 1'b0;
        end else begin
          quot_d = alog_q;
          dz_d   = 1'b0;
        end
        state_d = DONE;
      end
      DONE: begin
        if (div_if.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      ka_q    <= '0;
      kb_q    <= '0;
      xa_q    <= '0;
      xb_q    <= '0;
      za_q    <= 1'b0;
      zb_q    <= 1'b0;
      k_q     <= '0;
      m_q     <= '0;
      quot_q  <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ka_q    <= ka_d;
      kb_q    <= kb_d;
      xa_q    <= xa_d;
      xb_q    <= xb_d;
      za_q    <= za_d;
      zb_q    <= zb_d;
      k_q     <= k_d;
      m_q     <= m_d;
      quot_q  <= quot_d;
      dz_q    <= dz_d;
    end
  end

  // in_ready is held low for as long as reset is asserted.
  assign div_if.in_ready  = rst_n & (state_q == IDLE);
  assign div_if.out_valid = (state_q == DONE);
  assign div_if.quotient  = quot_q;
  assign div_if.dz        = dz_q;

endmodule

// File: tb/tb_log_div_seq.sv
// tb/tb_log_div_seq.sv - randomized self-checking bench for log_div_seq
module tb_log_div_seq;
  localparam int N    = 16;
  localparam int FRAC = 8;
  localparam int QW   = N + FRAC;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  log_div_seq_if #(.n(N), .FRAC(FRAC)) ifc ();

  log_div_seq #(.n(N), .FRAC(FRAC)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .div_if (ifc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int negcnt = 0;

  logic [QW-1:0] exp_q[$];
  logic          exp_dz[$];
  int            acc_t[$];
  bit            seen_valid = 0;

  task automatic check_eq(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic int floor_log2(input int unsigned v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) if (v >= (32'd1 << i)) r = i;
    return r;
  endfunction

  // Logs as fixed point with N-1 fractional bits: log2(v) ~ k + (v-2^k)/2^k.
  // Quotient = 2^floor(diff) * (1 + frac(diff)), scaled by 2^FRAC, floored.
  function automatic void model(input int unsigned av, input int unsigned bv,
                                output logic [QW-1:0] q, output logic d);
    longint la, lb, diff, k, fr, m, e;
    int ka, kb;
    if (bv == 0) begin
      q = '1; d = 1'b1;
    end else if (av == 0) begin
      q = '0; d = 1'b0;
    end else begin
      ka   = floor_log2(av);
      kb   = floor_log2(bv);
      la   = longint'(ka) * (64'sd1 << (N-1)) + (longint'(av) - (64'sd1 << ka)) * (64'sd1 << (N-1-ka));
      lb   = longint'(kb) * (64'sd1 << (N-1)) + (longint'(bv) - (64'sd1 << kb)) * (64'sd1 << (N-1-kb));
      diff = la - lb;
      k    = diff >>> (N-1);
      fr   = diff - k * (64'sd1 << (N-1));
      m    = (64'sd1 << (N-1)) + fr;
      e    = k + FRAC - (N-1);
      if (e >= 0) q = QW'(m * (64'sd1 << e));
      else        q = QW'(m / (64'sd1 << (-e)));
      d = 1'b0;
    end
  endfunction

  function automatic logic [N-1:0] rnd_op();
    int unsigned r;
    r = $urandom;
    case (r % 8)
      0:       return '0;
      1:       return 16'hFFFF;
      default: return N'(r >> 16) >> (r % 16);
    endcase
  endfunction

  // Compare process: scoreboard of accepted operations, checked every cycle
  // the result is presented. The accept is sampled one falling edge before
  // E0 and the result appears after E3, i.e. 4 falling edges later.
  always @(negedge clk) begin
    logic [QW-1:0] mq;
    logic          md;
    negcnt++;
    if (!rst_n) begin
      exp_q.delete();
      exp_dz.delete();
      acc_t.delete();
      seen_valid = 0;
    end else begin
      if (ifc.out_valid) begin
        check_eq("in_ready while result pending", ifc.in_ready, 0);
        if (exp_q.size() != 1) begin
          check_eq("scoreboard depth at out_valid", exp_q.size(), 1);
        end else begin
          if (!seen_valid) begin
            check_eq("latency falling edges", negcnt - acc_t[0], 4);
            seen_valid = 1;
          end
          check_eq("quotient", ifc.quotient, exp_q[0]);
          check_eq("dz", ifc.dz, exp_dz[0]);
          if (ifc.out_ready) begin
            void'(exp_q.pop_front());
            void'(exp_dz.pop_front());
            void'(acc_t.pop_front());
            seen_valid = 0;
          end
        end
      end else if (exp_q.size() > 0 && !seen_valid && (negcnt - acc_t[0]) > 4) begin
        check_eq("result overdue", ifc.out_valid, 1);
        seen_valid = 1;
      end
      if (ifc.in_valid && ifc.in_ready) begin
        check_eq("single op in flight", exp_q.size(), 0);
        model(ifc.a, ifc.b, mq, md);
        exp_q.push_back(mq);
        exp_dz.push_back(md);
        acc_t.push_back(negcnt);
      end
    end
  end

  task automatic run_op(input logic [N-1:0] av, input logic [N-1:0] bv,
                        input logic [QW-1:0] eq, input logic ed, input string nm);
    @(posedge clk); #1;
    ifc.a = av; ifc.b = bv; ifc.in_valid = 1'b1; ifc.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ifc.in_ready) break;
    end
    check_eq({nm, " in_ready at accept"}, ifc.in_ready, 1);
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (ifc.out_valid) break;
      @(negedge clk);
    end
    check_eq({nm, " out_valid"}, ifc.out_valid, 1);
    check_eq({nm, " quotient"}, ifc.quotient, eq);
    check_eq({nm, " dz"}, ifc.dz, ed);
  endtask

  initial begin
    logic [QW-1:0] mq;
    logic          md;
    logic [QW-1:0] hold_q;
    logic          hold_dz;

    ifc.in_valid  = 1'b0;
    ifc.a         = '0;
    ifc.b         = '0;
    ifc.out_ready = 1'b0;

    // Hand-computed values pin the reference model itself.
    model(100, 10, mq, md);    check_eq("model 100/10", mq, 24'h000A80);
    model(10, 100, mq, md);    check_eq("model 10/100", mq, 24'h00001B);
    model(37, 37, mq, md);     check_eq("model 37/37", mq, 24'h000100);
    model(65535, 1, mq, md);   check_eq("model 65535/1", mq, 24'hFFFF00);
    model(1, 65535, mq, md);   check_eq("model 1/65535", mq, 24'h000000);
    model(5, 0, mq, md);       check_eq("model 5/0 dz", md, 1);
    model(200, 3, mq, md);     check_eq("model 200/3", mq, 24'h004400);

    repeat (2) @(negedge clk);
    check_eq("reset in_ready", ifc.in_ready, 0);
    check_eq("reset out_valid", ifc.out_valid, 0);
    check_eq("reset quotient", ifc.quotient, 0);
    check_eq("reset dz", ifc.dz, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("in_ready after reset", ifc.in_ready, 1);

    run_op(100, 10, 24'h000A80, 1'b0, "100/10");
    run_op(10, 100, 24'h00001B, 1'b0, "10/100");
    run_op(37, 37, 24'h000100, 1'b0, "37/37");
    run_op(65535, 1, 24'hFFFF00, 1'b0, "65535/1");
    run_op(1, 65535, 24'h000000, 1'b0, "1/65535");
    run_op(5, 0, 24'hFFFFFF, 1'b1, "5/0");
    run_op(0, 7, 24'h000000, 1'b0, "0/7");

    // Back-pressure: hold DONE for 10 cycles while the inputs churn.
    model(200, 3, hold_q, hold_dz);
    @(posedge clk); #1;
    ifc.a = 200; ifc.b = 3; ifc.in_valid = 1'b1; ifc.out_ready = 1'b0;
    @(negedge clk);
    check_eq("hold in_ready at accept", ifc.in_ready, 1);
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (ifc.out_valid) break;
      @(negedge clk);
    end
    check_eq("hold out_valid reached", ifc.out_valid, 1);
    repeat (10) begin
      @(posedge clk); #1;
      ifc.a = rnd_op(); ifc.b = rnd_op(); ifc.in_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_eq("hold out_valid", ifc.out_valid, 1);
      check_eq("hold in_ready", ifc.in_ready, 0);
      check_eq("hold quotient", ifc.quotient, hold_q);
    end
    @(posedge clk); #1;
    ifc.in_valid = 1'b0; ifc.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_eq("release out_valid", ifc.out_valid, 0);
    check_eq("release in_ready", ifc.in_ready, 1);
    check_eq("release quotient kept", ifc.quotient, hold_q);

    // Asynchronous reset while the operation sits in SUB.
    @(posedge clk); #1;
    ifc.a = 300; ifc.b = 7; ifc.in_valid = 1'b1;
    @(posedge clk); #1;          // E0: accepted, now in LOG
    ifc.in_valid = 1'b0;
    @(posedge clk); #2;          // E1: now in SUB
    rst_n = 1'b0;
    #1;
    check_eq("async reset out_valid", ifc.out_valid, 0);
    check_eq("async reset quotient", ifc.quotient, 0);
    check_eq("async reset in_ready", ifc.in_ready, 0);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post reset in_ready", ifc.in_ready, 1);
    repeat (5) begin
      @(negedge clk);
      check_eq("abandoned op silent", ifc.out_valid, 0);
    end
    run_op(100, 10, 24'h000A80, 1'b0, "post reset 100/10");

    // Randomized traffic with random back-pressure.
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      ifc.in_valid  = 1'($urandom_range(0, 1));
      ifc.a         = rnd_op();
      ifc.b         = rnd_op();
      ifc.out_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b1;
    repeat (10) @(negedge clk);
    check_eq("scoreboard drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
